vector_reg_responder: RTL and testbench
=======================================

VECTOR_REG_RESPONDER -- requirements
Module: vector_reg_responder

Interface
REQ-001 SHALL have parameter VECTOR_DEPTH, default 64, meaning elements per vector register (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port reg_req  input  cntrl_req_t [NUM_OF_LANES-1:0]  per-lane request (vld, access_type, access_length, stride_type, vec_reg_ptr, addr, data).
REQ-005 SHALL have port reg_req_grant  output  1 [NUM_OF_LANES-1:0]  one-cycle acceptance pulse per lane.
REQ-006 SHALL have port reg_rsp_vld  output  1 [NUM_OF_LANES-1:0]  read element valid per lane.
REQ-007 SHALL have port reg_rsp_data  output  VECTOR_REG_WIDTH [NUM_OF_LANES-1:0]  read element data per lane.
REQ-008 SHALL have port reg_busy  output  1 [NUM_OF_LANES-1:0]  lane not IDLE.

Function
REQ-009 SHALL hold NUM_OF_VECTOR_REG x VECTOR_DEPTH elements of VECTOR_REG_WIDTH bits.
REQ-010 SHALL run one independent FSM per lane with states IDLE, READ_BURST, WRITE.
REQ-011 IDLE with reg_req.vld=1 in cycle T SHALL capture the request, pulse reg_req_grant in T+1 only, and enter READ_BURST (READ_REQ) or WRITE (WRITE_REQ).
REQ-012 reg_req.vld while not IDLE SHALL be ignored, with no grant and no queuing.
REQ-013 READ_BURST SHALL present element count N = max(access_length,1) on reg_rsp_vld/reg_rsp_data on consecutive cycles T+2 .. T+1+N, then return to IDLE.
REQ-014 Element index k SHALL be (addr + k*step) mod VECTOR_DEPTH, where step=1 for NON_STRIDE.
REQ-015 WRITE SHALL store data at element addr mod VECTOR_DEPTH of vec_reg_ptr in cycle T+1, with no reg_rsp_vld, and return to IDLE in T+2.
REQ-016 A lane back in IDLE SHALL accept a new request the same cycle it returns, so back-to-back reads are gap-free after the grant cycle.
REQ-017 Reads SHALL return the pre-write value on a same-cycle read/write to the same element; the new value is visible from the next cycle.
REQ-018 Simultaneous writes to the same element SHALL commit only the lowest-numbered lane.
REQ-019 reg_rsp_data SHALL be 0 whenever reg_rsp_vld=0.
REQ-020 reg_busy SHALL be 1 from T+1 until the FSM returns to IDLE.

Reset
REQ-021 reset low SHALL immediately force all FSMs to IDLE, reg_req_grant=0, reg_rsp_vld=0, reg_rsp_data=0, reg_busy=0, and all storage to 0.
REQ-022 Reset mid-burst SHALL abort the burst with no further responses; after reset release, the first request is served per REQ-011.

Configuration
REQ-023 Macro VREG_STRIDE_EN defined: STRIDE requests SHALL use step = data[7:0] captured at acceptance; step 0 repeats element addr N times.
REQ-024 Macro VREG_STRIDE_EN undefined: STRIDE requests SHALL behave exactly as NON_STRIDE, and no stride register is built.

Structure
REQ-025 cntrl_req_t, READ_REQ/WRITE_REQ, NON_STRIDE/STRIDE, v_register_t, NUM_OF_LANES, VECTOR_REG_WIDTH, NUM_OF_VECTOR_REG and VECTOR_DEPTH SHALL come from the shared package.
REQ-026 Per-lane FSM, counter and address generator SHALL be sub-module vreg_port_fsm, instantiated NUM_OF_LANES times; storage and write arbitration stay in the top.

Verification
REQ-027 Write lane0 reg 3 elem 5 = 0xAA, then read reg 3 addr 5 len 1 -> grant one cycle after vld; rsp_vld one cycle later with data 0xAA.
REQ-028 Preload reg 1 elem i = i; read lane1 addr 62 len 4, VECTOR_DEPTH=64 -> data 62, 63, 0, 1 on four consecutive cycles, then busy=0.
REQ-029 Lane0 and lane1 write reg 2 elem 0 the same cycle with 0x11 and 0x22 -> subsequent read returns 0x11.
REQ-030 Assert reset during the third beat of a len-8 read -> outputs 0 immediately, no further rsp_vld, storage reads 0 after release.
REQ-031 VREG_STRIDE_EN defined, STRIDE read addr 0 step 4 len 3 on preload i -> 0, 4, 8; undefined -> 0, 1, 2.
REQ-032 Request with vld held while busy -> no second grant until IDLE, then granted once.

Source files
------------

// File: rtl/vector_reg_responder_pkg.sv
// Shared types and sizing for the vector register responder.
// Lane count, element width and register file shape live here so every lane agrees.
package vector_reg_responder_pkg;

  localparam int NUM_OF_LANES      = 2;
  localparam int VECTOR_REG_WIDTH  = 32;
  localparam int NUM_OF_VECTOR_REG = 4;
  localparam int VECTOR_DEPTH      = 64;
  localparam int VREG_PTR_W        = $clog2(NUM_OF_VECTOR_REG);
  localparam int ADDR_W            = 8;
  localparam int LEN_W             = 8;

  typedef enum logic { READ_REQ  = 1'b0, WRITE_REQ = 1'b1 } access_type_t;
  typedef enum logic { NON_STRIDE = 1'b0, STRIDE   = 1'b1 } stride_type_t;

  typedef logic [VECTOR_REG_WIDTH-1:0] v_register_t;

  typedef struct packed {
    logic                  vld;
    access_type_t          access_type;
    logic [LEN_W-1:0]      access_length;
    stride_type_t          stride_type;
    logic [VREG_PTR_W-1:0] vec_reg_ptr;
    logic [ADDR_W-1:0]     addr;
    v_register_t           data;
  } cntrl_req_t;

endpackage

// File: rtl/vector_reg_responder_if.sv
// Per-lane request/response bundle between requesters and the vector register responder.
interface vector_reg_responder_if;
  import vector_reg_responder_pkg::*;

  cntrl_req_t  [NUM_OF_LANES-1:0] reg_req;
  logic        [NUM_OF_LANES-1:0] reg_req_grant;
  logic        [NUM_OF_LANES-1:0] reg_rsp_vld;
  v_register_t [NUM_OF_LANES-1:0] reg_rsp_data;
  logic        [NUM_OF_LANES-1:0] reg_busy;

  modport master (output reg_req, input reg_req_grant, reg_rsp_vld, reg_rsp_data, reg_busy);
  modport slave  (input reg_req, output reg_req_grant, reg_rsp_vld, reg_rsp_data, reg_busy);

endinterface

// File: rtl/vreg_port_fsm.sv
// One lane's request FSM, beat counter and element address generator.
// VREG_STRIDE_EN adds a captured per-request step; otherwise every burst walks by one.
module vreg_port_fsm
  import vector_reg_responder_pkg::*;
#(
  parameter  int VECTOR_DEPTH = vector_reg_responder_pkg::VECTOR_DEPTH,
  localparam int IDX_W        = $clog2(VECTOR_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  cntrl_req_t            req,
  output logic                  grant,
  output logic                  busy,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [VREG_PTR_W-1:0] ptr,
  output logic [IDX_W-1:0]      idx,
  output v_register_t           wr_data
);

  typedef enum logic [1:0] { IDLE, READ_BURST, WRITE } state_t;

  state_t                state_q, state_d;
  logic                  grant_q;
  logic [LEN_W-1:0]      left_q;
  logic [IDX_W-1:0]      idx_q;
  logic [VREG_PTR_W-1:0] ptr_q;
  v_register_t           data_q;
  logic [IDX_W-1:0]      step;
  logic                  accept;
  logic                  unused_req_bits;

  assign accept          = (state_q == IDLE) && req.vld;
  assign unused_req_bits = ^{req.addr, req.stride_type};

`ifdef VREG_STRIDE_EN
  logic [7:0] step_q;
  always_ff @(posedge clk) begin
    if (accept) step_q <= (req.stride_type == STRIDE) ? req.data[7:0] : 8'd1;
  end
  assign step = IDX_W'(step_q);
`else
  assign step = IDX_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (req.vld) state_d = (req.access_type == WRITE_REQ) ? WRITE : READ_BURST;
      READ_BURST: if (left_q <= LEN_W'(1)) state_d = IDLE;
      WRITE:      state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= accept;
      if (accept)
        left_q <= (req.access_length == '0) ? LEN_W'(1) : req.access_length;
      else if (state_q == READ_BURST)
        left_q <= left_q - LEN_W'(1);
    end
  end

  // Address path: element index advances by the step once per issued beat.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q  <= req.addr[IDX_W-1:0];
      ptr_q  <= req.vec_reg_ptr;
      data_q <= req.data;
    end else if (state_q == READ_BURST) begin
      idx_q  <= idx_q + step;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign rd_en   = (state_q == READ_BURST);
  assign wr_en   = (state_q == WRITE);
  assign ptr     = ptr_q;
  assign idx     = idx_q;
  assign wr_data = data_q;

endmodule

// File: rtl/vector_reg_responder.sv
// Multi-lane vector register file: per-lane FSMs, shared storage, lowest-lane-wins writes.
// Optional VREG_STRIDE_EN enables strided read bursts inside each lane FSM.
module vector_reg_responder
  import vector_reg_responder_pkg::*;
#(
  parameter  int VECTOR_DEPTH = vector_reg_responder_pkg::VECTOR_DEPTH,
  localparam int IDX_W        = $clog2(VECTOR_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  vector_reg_responder_if.slave  bus
);

  v_register_t mem [NUM_OF_VECTOR_REG][VECTOR_DEPTH];

  logic        [NUM_OF_LANES-1:0] grant, busy, rd_en, wr_en;
  logic        [VREG_PTR_W-1:0]   ptr     [NUM_OF_LANES];
  logic        [IDX_W-1:0]        idx     [NUM_OF_LANES];
  v_register_t                    wr_data [NUM_OF_LANES];

  logic        [NUM_OF_LANES-1:0] rsp_vld_p1;
  v_register_t [NUM_OF_LANES-1:0] rsp_data_p1;

  for (genvar g = 0; g < NUM_OF_LANES; g++) begin : g_lane
    vreg_port_fsm #(.VECTOR_DEPTH(VECTOR_DEPTH)) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.reg_req[g]),
      .grant   (grant[g]),
      .busy    (busy[g]),
      .rd_en   (rd_en[g]),
      .wr_en   (wr_en[g]),
      .ptr     (ptr[g]),
      .idx     (idx[g]),
      .wr_data (wr_data[g])
    );
  end

  // Stage p1: registered read beat; writes land on the same edge so a colliding read sees old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_OF_VECTOR_REG; r++)
        for (int e = 0; e < VECTOR_DEPTH; e++)
          mem[r][e] <= '0;
      rsp_vld_p1  <= '0;
      rsp_data_p1 <= '0;
    end else begin
      for (int l = 0; l < NUM_OF_LANES; l++) begin
        rsp_vld_p1[l]  <= rd_en[l];
        rsp_data_p1[l] <= rd_en[l] ? mem[ptr[l]][idx[l]] : '0;
      end
      // Descending order so the lowest-numbered lane's write is the one that sticks.
      for (int l = NUM_OF_LANES-1; l >= 0; l--)
        if (wr_en[l]) mem[ptr[l]][idx[l]] <= wr_data[l];
    end
  end

  assign bus.reg_req_grant = grant;
  assign bus.reg_busy      = busy;
  assign bus.reg_rsp_vld   = rsp_vld_p1;
  assign bus.reg_rsp_data  = rsp_data_p1;

endmodule

// File: tb/tb_vector_reg_responder.sv
// Bench for vector_reg_responder: vector table plus hand-written corner sequences,
// with per-lane expected-response queues drained by a negedge monitor.
module tb_vector_reg_responder;
  import vector_reg_responder_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  v_register_t exp_q [NUM_OF_LANES][$];

  vector_reg_responder_if bus();

  vector_reg_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    bit          wr;
    bit          stride;
    int          ptr;
    int          addr;
    int          len;
    logic [31:0] data;
    int          n;
    logic [31:0] e [4];
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cntrl_req_t make_req(bit wr, bit stride, int ptr, int addr, int len,
                                          logic [31:0] data);
    cntrl_req_t r;
    r.vld           = 1'b1;
    r.access_type   = wr ? WRITE_REQ : READ_REQ;
    r.access_length = LEN_W'(len);
    r.stride_type   = stride ? STRIDE : NON_STRIDE;
    r.vec_reg_ptr   = VREG_PTR_W'(ptr);
    r.addr          = ADDR_W'(addr);
    r.data          = data;
    return r;
  endfunction

  function automatic vec_t mk(int lane, bit wr, bit stride, int ptr, int addr, int len,
                              logic [31:0] data, int n, logic [31:0] e0, logic [31:0] e1,
                              logic [31:0] e2, logic [31:0] e3);
    vec_t v;
    v.lane = lane; v.wr = wr; v.stride = stride; v.ptr = ptr; v.addr = addr;
    v.len = len; v.data = data; v.n = n;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  // Response monitor: every valid beat must match the oldest expected value for its lane.
  always @(negedge clk) begin
    for (int l = 0; l < NUM_OF_LANES; l++) begin
      if (bus.reg_rsp_vld[l]) begin
        if (exp_q[l].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp lane%0d: got data %h, expected no response", l,
                   bus.reg_rsp_data[l]);
        end else begin
          chk($sformatf("rsp_data lane%0d", l), bus.reg_rsp_data[l], exp_q[l].pop_front());
        end
      end else begin
        chk($sformatf("idle_data lane%0d", l), bus.reg_rsp_data[l], '0);
      end
    end
  end

  // Called at posedge+1 of cycle T; returns at posedge+1 of T+1 after checking the grant.
  task automatic issue(input int lane, input bit wr, input bit stride, input int ptr,
                       input int addr, input int len, input logic [31:0] data);
    bus.reg_req[lane] = make_req(wr, stride, ptr, addr, len, data);
    @(posedge clk); #1;
    bus.reg_req[lane].vld = 1'b0;
    chk($sformatf("grant lane%0d", lane), 32'(bus.reg_req_grant[lane]), 32'd1);
    chk($sformatf("busy_t1 lane%0d", lane), 32'(bus.reg_busy[lane]), 32'd1);
  endtask

  task automatic wait_idle(input int lane);
    int k;
    for (k = 0; k < 200; k++) begin
      if (!bus.reg_busy[lane]) break;
      @(posedge clk); #1;
    end
    if (k == 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle lane%0d: got busy after %0d cycles, expected idle", lane, k);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < v.n; i++) exp_q[v.lane].push_back(v.e[i]);
    issue(v.lane, v.wr, v.stride, v.ptr, v.addr, v.len, v.data);
    if (v.wr) begin
      @(posedge clk); #1;
      chk("write_done_busy", 32'(bus.reg_busy[v.lane]), 32'd0);
      chk("write_grant_pulse", 32'(bus.reg_req_grant[v.lane]), 32'd0);
    end else begin
      n = (v.len == 0) ? 1 : v.len;
      repeat (n) begin @(posedge clk); #1; end
      chk("last_beat_vld", 32'(bus.reg_rsp_vld[v.lane]), 32'd1);
      chk("last_beat_busy", 32'(bus.reg_busy[v.lane]), 32'd0);
      @(posedge clk); #1;
      chk("queue_drained", 32'(exp_q[v.lane].size()), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_req = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", 32'(bus.reg_req_grant), 32'd0);
    chk("reset_vld",   32'(bus.reg_rsp_vld), 32'd0);
    chk("reset_data",  32'(bus.reg_rsp_data[0] | bus.reg_rsp_data[1]), 32'd0);
    chk("reset_busy",  32'(bus.reg_busy), 32'd0);
    reset = 1'b1;

    // Single write then single read of the same element.
    run_vec(mk(0, 1, 0, 3, 5, 1, 32'hAA, 0, 0, 0, 0, 0));
    run_vec(mk(0, 0, 0, 3, 5, 1, 0, 1, 32'hAA, 0, 0, 0));

    // Preload reg 1 with elem i = i.
    for (int i = 0; i < VECTOR_DEPTH; i++)
      run_vec(mk(0, 1, 0, 1, i, 1, 32'(i), 0, 0, 0, 0, 0));

    tbl[0] = mk(1, 0, 0, 1, 62, 4, 0,       4, 62, 63, 0, 1);
    tbl[1] = mk(0, 0, 0, 1, 10, 0, 0,       1, 10, 0, 0, 0);
    tbl[2] = mk(1, 1, 0, 0, 70, 1, 32'h1234, 0, 0, 0, 0, 0);
    tbl[3] = mk(0, 0, 0, 0, 6,  1, 0,       1, 32'h1234, 0, 0, 0);
`ifdef VREG_STRIDE_EN
    tbl[4] = mk(1, 0, 1, 1, 0,  3, 4,       3, 0, 4, 8, 0);
    tbl[5] = mk(0, 0, 1, 1, 7,  3, 0,       3, 7, 7, 7, 0);
    tbl[7] = mk(0, 0, 1, 1, 60, 4, 3,       4, 60, 63, 2, 5);
`else
    tbl[4] = mk(1, 0, 1, 1, 0,  3, 4,       3, 0, 1, 2, 0);
    tbl[5] = mk(0, 0, 1, 1, 7,  3, 0,       3, 7, 8, 9, 0);
    tbl[7] = mk(0, 0, 1, 1, 60, 4, 3,       4, 60, 61, 62, 63);
`endif
    tbl[6] = mk(1, 0, 0, 3, 5,  2, 0,       2, 32'hAA, 0, 0, 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Same-cycle writes from both lanes to one element: lane 0 must win.
    @(posedge clk); #1;
    bus.reg_req[0] = make_req(1, 0, 2, 0, 1, 32'h11);
    bus.reg_req[1] = make_req(1, 0, 2, 0, 1, 32'h22);
    @(posedge clk); #1;
    bus.reg_req[0].vld = 1'b0;
    bus.reg_req[1].vld = 1'b0;
    chk("dual_wr_grants", 32'(bus.reg_req_grant), 32'd3);
    run_vec(mk(1, 0, 0, 2, 0, 1, 0, 1, 32'h11, 0, 0, 0));

    // Read and write of the same element issued together: read sees the old value.
    @(posedge clk); #1;
    exp_q[0].push_back(32'h11);
    bus.reg_req[0] = make_req(0, 0, 2, 0, 1, 0);
    bus.reg_req[1] = make_req(1, 0, 2, 0, 1, 32'h33);
    @(posedge clk); #1;
    bus.reg_req[0].vld = 1'b0;
    bus.reg_req[1].vld = 1'b0;
    chk("rw_grants", 32'(bus.reg_req_grant), 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    run_vec(mk(0, 0, 0, 2, 0, 1, 0, 1, 32'h33, 0, 0, 0));

    // vld held through a burst: granted once now, once again only after IDLE.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      exp_q[0].push_back(32'd20); exp_q[0].push_back(32'd21); exp_q[0].push_back(32'd22);
    end
    bus.reg_req[0] = make_req(0, 0, 1, 20, 3, 0);
    @(posedge clk); #1;
    chk("hold_grant_t1", 32'(bus.reg_req_grant[0]), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_nogrant_t%0d", k), 32'(bus.reg_req_grant[0]), 32'd0);
    end
    @(posedge clk); #1;
    chk("hold_regrant", 32'(bus.reg_req_grant[0]), 32'd1);
    bus.reg_req[0].vld = 1'b0;
    wait_idle(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_queue_drained", 32'(exp_q[0].size()), 32'd0);
    chk("hold_no_third_grant", 32'(bus.reg_req_grant[0]), 32'd0);

    // Reset during the third beat of a length-8 burst.
    @(posedge clk); #1;
    exp_q[0].push_back(32'd0);
    exp_q[0].push_back(32'd1);
    issue(0, 0, 0, 1, 0, 8, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("beat3_vld",  32'(bus.reg_rsp_vld[0]), 32'd1);
    chk("beat3_data", bus.reg_rsp_data[0], 32'd2);
    reset = 1'b0;
    #1;
    chk("rst_mid_vld",   32'(bus.reg_rsp_vld), 32'd0);
    chk("rst_mid_data",  bus.reg_rsp_data[0], 32'd0);
    chk("rst_mid_busy",  32'(bus.reg_busy), 32'd0);
    chk("rst_mid_grant", 32'(bus.reg_req_grant), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("rst_queue_empty", 32'(exp_q[0].size()), 32'd0);
    run_vec(mk(0, 0, 0, 1, 5, 1, 0, 1, 0, 0, 0, 0));
    run_vec(mk(1, 0, 0, 3, 5, 1, 0, 1, 0, 0, 0, 0));
    run_vec(mk(0, 0, 0, 2, 0, 1, 0, 1, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("final_q0", 32'(exp_q[0].size()), 32'd0);
    chk("final_q1", 32'(exp_q[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
